// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a one-cycle registered write port.
// Define RF_WB_RR_EN for round-robin tie breaking; otherwise requester 1 wins every tie.
module rf_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             rf_write,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic             last_grant,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              both_p0;
  logic              tie_pick1_p0;
  logic              pick1_p0;
  logic              vld_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational arbitration and handshake
  always_comb begin
    both_p0 = req0_valid & req1_valid;
`ifdef RF_WB_RR_EN
    tie_pick1_p0 = ~last_grant;
`else
    tie_pick1_p0 = 1'b1;
`endif
    pick1_p0   = req1_valid & (~req0_valid | tie_pick1_p0);
    req1_ready = rst & pick1_p0;
    req0_ready = rst & req0_valid & ~pick1_p0;
    vld_p0     = req0_ready | req1_ready;
    addr_p0    = pick1_p0 ? req1_addr : req0_addr;
    data_p0    = pick1_p0 ? req1_data : req0_data;
    // x0 writes complete the handshake but never reach the register file
    wr_p0      = vld_p0 & (addr_p0 != '0);
  end

  // Stage p1: registered register-file write port and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_write     <= 1'b0;
      rf_addr      <= '0;
      rf_data      <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      rf_write <= wr_p0;
      if (wr_p0) begin
        rf_addr <= addr_p0;
        rf_data <= data_p0;
      end
      if (vld_p0)
        last_grant <= pick1_p0;
      if (both_p0)
        conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter; tie expectations follow RF_WB_RR_EN when defined.
module tb_rf_wb_arbiter;
  localparam int CNT_W = 4;
`ifdef RF_WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [4:0]       req0_addr, req1_addr;
  logic [31:0]      req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             rf_write;
  logic [4:0]       rf_addr;
  logic [31:0]      rf_data;
  logic             last_grant;
  logic [CNT_W-1:0] conflict_cnt;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_lg;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .last_grant(last_grant), .conflict_cnt(conflict_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  // Expected register-file port for the cycle after this one
  task automatic push_exp(input logic acc, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    if (acc && a != 5'd0) begin
      m_addr = a;
      m_data = d;
      e = '{wr: 1'b1, addr: a, data: d};
    end else begin
      e = '{wr: 1'b0, addr: m_addr, data: m_data};
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    rst = 1'b1;
    m_addr = '0;
    m_data = '0;
    m_lg = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready);
    end
    tick;
    tick;
    n_cmp++;
    if (rf_write !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rf: got %b/%h/%h required 0/00/00000000", rf_write, rf_addr, rf_data);
    end
    n_cmp++;
    if (last_grant !== 1'b1 || conflict_cnt !== '0) begin
      n_fail++; $display("FAIL reset_status: got lg=%b cnt=%0d required lg=1 cnt=0", last_grant, conflict_cnt);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_addr = '0; m_data = '0; m_lg = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_single;
    exp_t e;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got %b%b required 10", req0_ready, req1_ready);
    end
    push_exp(1, 5'd5, 32'hDEADBEEF);
    m_lg = 1'b0;
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL single_write: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    n_cmp++;
    if (last_grant !== m_lg) begin
      n_fail++; $display("FAIL single_lg: got %b required %b", last_grant, m_lg);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    push_exp(0, 0, 0);
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL single_idle: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
  endtask

  task automatic test_tie;
    exp_t e;
    logic w;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 32'hA0A00001, 1, 5'd2, 32'hB1B10002);
      #1;
      w = RR ? ~m_lg : 1'b1;
      n_cmp++;
      if (req1_ready !== w || req0_ready !== ~w) begin
        n_fail++; $display("FAIL tie_grant[%0d]: got r0=%b r1=%b required r1=%b", i, req0_ready, req1_ready, w);
      end
      push_exp(1, w ? 5'd2 : 5'd1, w ? 32'hB1B10002 : 32'hA0A00001);
      m_lg = w;
      tick;
      e = exp_q.pop_front();
      n_cmp++;
      if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
        n_fail++; $display("FAIL tie_write[%0d]: got %b/%h/%h required %b/%h/%h", i, rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (conflict_cnt !== CNT_W'(4)) begin
      n_fail++; $display("FAIL tie_cnt: got %0d required 4", conflict_cnt);
    end
    n_cmp++;
    if (last_grant !== m_lg) begin
      n_fail++; $display("FAIL tie_lg: got %b required %b", last_grant, m_lg);
    end
  endtask

  task automatic test_x0;
    exp_t e;
    drive(1, 5'd3, 32'h33, 0, 0, 0);
    #1;
    push_exp(1, 5'd3, 32'h33);
    m_lg = 1'b0;
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL x0_pre: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    drive(0, 0, 0, 1, 5'd0, 32'h12345678);
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL x0_ready: got %b%b required 01", req0_ready, req1_ready);
    end
    push_exp(1, 5'd0, 32'h12345678);
    m_lg = 1'b1;
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL x0_write: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    n_cmp++;
    if (last_grant !== 1'b1) begin
      n_fail++; $display("FAIL x0_lg: got %b required 1", last_grant);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic w;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if (i % 2 == 0) drive(1, 5'(8 + i), d, 0, 0, 0);
      else            drive(0, 0, 0, 1, 5'(8 + i), d);
      #1;
      n_cmp++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b%b", i, req0_ready, req1_ready);
      end
      push_exp(1, 5'(8 + i), d);
      m_lg = (i % 2 == 1);
      tick;
      e = exp_q.pop_front();
      n_cmp++;
      if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
        n_fail++; $display("FAIL b2b_write[%0d]: got %b/%h/%h required %b/%h/%h", i, rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
      end
    end
    // Same-address tie: the loser keeps its request stable and lands last
    w = RR ? ~m_lg : 1'b1;
    drive(1, 5'd9, 32'h900, 1, 5'd9, 32'h901);
    #1;
    n_cmp++;
    if (req1_ready !== w || req0_ready !== ~w) begin
      n_fail++; $display("FAIL same_grant: got r0=%b r1=%b required r1=%b", req0_ready, req1_ready, w);
    end
    push_exp(1, 5'd9, w ? 32'h901 : 32'h900);
    m_lg = w;
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL same_first: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    if (w) drive(1, 5'd9, 32'h900, 0, 0, 0);
    else   drive(0, 0, 0, 1, 5'd9, 32'h901);
    #1;
    n_cmp++;
    if (req0_ready !== w || req1_ready !== ~w) begin
      n_fail++; $display("FAIL same_second: got r0=%b r1=%b required r0=%b", req0_ready, req1_ready, w);
    end
    push_exp(1, 5'd9, w ? 32'h900 : 32'h901);
    m_lg = ~w;
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL same_final: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    push_exp(0, 0, 0);
    tick;
    e = exp_q.pop_front();
    n_cmp++;
    if (rf_write !== e.wr || rf_addr !== e.addr || rf_data !== e.data) begin
      n_fail++; $display("FAIL b2b_idle: got %b/%h/%h required %b/%h/%h", rf_write, rf_addr, rf_data, e.wr, e.addr, e.data);
    end
    n_cmp++;
    if (last_grant !== m_lg) begin
      n_fail++; $display("FAIL b2b_lg: got %b required %b", last_grant, m_lg);
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 5'd7, 32'h77, 0, 0, 0);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_accept: got %b required 1", req0_ready);
    end
    tick;
    rst = 1'b0;
    drive(1, 5'd7, 32'h77, 1, 5'd4, 32'h44);
    #1;
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready: got %b%b required 00", req0_ready, req1_ready);
    end
    tick;
    n_cmp++;
    if (rf_write !== 1'b0 || rf_addr !== 5'd0 || conflict_cnt !== '0) begin
      n_fail++; $display("FAIL mid_state: got wr=%b addr=%h cnt=%0d required 0/00/0", rf_write, rf_addr, conflict_cnt);
    end
    n_cmp++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready2: got %b%b required 00", req0_ready, req1_ready);
    end
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_addr = '0; m_data = '0; m_lg = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_saturation;
    logic [CNT_W-1:0] want;
    do_reset;
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
      tick;
      want = (i + 1 > 15) ? CNT_W'(15) : CNT_W'(i + 1);
      n_cmp++;
      if (conflict_cnt !== want) begin
        n_fail++; $display("FAIL sat_cnt[%0d]: got %0d required %0d", i, conflict_cnt, want);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    m_addr = '0; m_data = '0; m_lg = 1'b1;
    tick;
    test_reset;
    test_single;
    test_tie;
    test_x0;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the conflict counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  execute-stage writeback request.
REQ-005 req0_addr  input  5  destination register index for requester 0.
REQ-006 req0_data  input  32  writeback value for requester 0.
REQ-007 req0_ready  output  1  grant to requester 0 (combinational).
REQ-008 req1_valid  input  1  load-unit writeback request.
REQ-009 req1_addr  input  5  destination register index for requester 1.
REQ-010 req1_data  input  32  writeback value for requester 1.
REQ-011 req1_ready  output  1  grant to requester 1 (combinational).
REQ-012 rf_write  output  1  register-file write enable (registered).
REQ-013 rf_addr  output  5  register-file write index (registered).
REQ-014 rf_data  output  32  register-file write data (registered).
REQ-015 last_grant  output  1  index of the most recently accepted requester (registered).
REQ-016 conflict_cnt  output  CNT_W  saturating count of cycles in which both requests were valid.

Function
REQ-017 A transfer SHALL complete in any cycle where reqN_valid and reqN_ready are both 1; at most one transfer completes per cycle.
REQ-018 reqN_ready SHALL be 1 only when reqN_valid is 1 and requester N wins arbitration in that cycle.
REQ-019 When exactly one requester is valid, that requester SHALL win.
REQ-020 When both requesters are valid, arbitration SHALL follow REQ-033/REQ-034; the loser's ready SHALL be 0 and it SHALL hold valid, addr and data stable until granted.
REQ-021 Latency: a transfer accepted in cycle T SHALL drive rf_addr/rf_data with the accepted values and rf_write=1 in cycle T+1.
REQ-022 rf_write SHALL be high for exactly one cycle per accepted transfer with addr != 0, and low in every cycle following a non-transfer.
REQ-023 A transfer with addr 0 SHALL complete the handshake but SHALL leave rf_write=0 and rf_addr/rf_data unchanged in the next cycle.
REQ-024 last_grant SHALL update to the winning index on every completed transfer, including addr-0 transfers, and SHALL hold otherwise.
REQ-025 conflict_cnt SHALL increment by 1 in each cycle with req0_valid=1 and req1_valid=1, SHALL saturate at all-ones, and SHALL never wrap.
REQ-026 Back-to-back transfers SHALL be sustained: one accepted transfer per cycle, with rf_write high in consecutive cycles.
REQ-027 Simultaneous same-address requests SHALL be serialized in grant order, so the later-granted data is the final register-file value.

Reset
REQ-028 While rst=0 at a rising edge, the next state SHALL be: rf_write=0, rf_addr=0, rf_data=0, last_grant=1, conflict_cnt=0.
REQ-029 While rst=0, req0_ready and req1_ready SHALL be 0, and no transfer SHALL complete.
REQ-030 A transfer accepted in the cycle before reset asserts SHALL be dropped: rf_write SHALL be 0 in the first cycle after the reset edge.
REQ-031 The first cycle with rst=1 SHALL arbitrate normally from the reset state.

Configuration
REQ-032 Macro RF_WB_RR_EN SHALL select the arbitration policy at compile time.
REQ-033 With RF_WB_RR_EN defined, when both are valid the block SHALL grant the requester not equal to last_grant (round-robin; requester 0 wins the first tie after reset).
REQ-034 Without RF_WB_RR_EN, when both are valid the block SHALL always grant requester 1 (fixed priority); last_grant SHALL still be maintained.

Verification
REQ-035 Single request: req0 valid, addr=5, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle rf_write=1, rf_addr=5, rf_data=0xDEADBEEF; following cycle rf_write=0.
REQ-036 Tie, RR build: both valid for 4 cycles after reset (req0 addr=1, req1 addr=2) -> grants alternate 0,1,0,1; rf_addr sequence 1,2,1,2 one cycle later; conflict_cnt=4.
REQ-037 Tie, fixed build: both valid for 3 cycles -> req1 granted all 3 cycles, req0_ready=0 throughout; conflict_cnt=3.
REQ-038 x0 write: req1 valid, addr=0, data=0x12345678 -> req1_ready=1; next cycle rf_write=0, rf_data unchanged; last_grant=1.
REQ-039 Reset mid-operation: accept req0 addr=7, then drive rst=0 on the next edge -> rf_write=0, rf_addr=0, conflict_cnt=0, both readys 0 while rst=0.
REQ-040 Saturation: CNT_W=4, both valid for 20 cycles -> conflict_cnt reaches 15 and holds at 15.
